id_issue_ctrl: RTL and testbench
================================

ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

Interface
REQ-001 SHALL have parameter LOAD_USE_BUBBLES, default 1, bubbles inserted on load-use (legal 1..3).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_valid  input  1  IF presents an instruction.
REQ-005 SHALL have port if_instr  input  32  RV32I instruction word from IF.
REQ-006 SHALL have port if_pc  input  32  PC of if_instr.
REQ-007 SHALL have port id_ready  output  1  ID can accept this cycle.
REQ-008 SHALL have port ex_valid  output  1  instruction offered to EX.
REQ-009 SHALL have port ex_instr  output  32  offered instruction word (feeds decoder/immediate extension).
REQ-010 SHALL have port ex_pc  output  32  PC of ex_instr.
REQ-011 SHALL have port ex_ready  input  1  EX accepts / pipeline advances this cycle.
REQ-012 SHALL have port flush  input  1  taken branch/jump resolved in EX; kill ID contents.
REQ-013 SHALL have port hazard_stall  output  1  load-use stall active this cycle.
REQ-014 SHALL have port stall_cnt  output  32  saturating count of hazard_stall cycles.

Function
REQ-015 SHALL hold one ID slot: id_valid, id_instr, id_pc registers.
REQ-016 SHALL decode opcode class from instr[6:2]; bits [1:0] ignored.
REQ-017 rs1 SHALL count as used for all opcodes except 01101 (LUI), 00101 (AUIPC), 11011 (JAL).
REQ-018 rs2 SHALL count as used only for 01100 (R), 01000 (store), 11000 (branch).
REQ-019 SHALL keep pending-load state ld_rd[4:0], ld_cnt[1:0].
REQ-020 hazard SHALL = id_valid & ld_cnt!=0 & ld_rd!=0 & ((rs1 used & instr[19:15]==ld_rd) | (rs2 used & instr[24:20]==ld_rd)).
REQ-021 ex_valid SHALL = id_valid & !hazard & !flush (combinational); ex_instr/ex_pc SHALL = id_instr/id_pc.
REQ-022 issue SHALL = ex_valid & ex_ready.
REQ-023 id_ready SHALL = !flush & (!id_valid | issue).
REQ-024 accept SHALL = if_valid & id_ready; on accept, slot loads if_instr/if_pc, id_valid<=1 next cycle.
REQ-025 issue without accept SHALL clear id_valid; issue with accept SHALL load new instruction with no empty cycle (full throughput).
REQ-026 on issue of opcode 00000 (load) with rd!=0: ld_rd<=instr[11:7], ld_cnt<=LOAD_USE_BUBBLES.
REQ-027 otherwise, when ex_ready=1 and ld_cnt!=0: ld_cnt decrements by 1 (bubble advances downstream).
REQ-028 when ex_ready=0, ld_cnt SHALL hold; ex_valid, ex_instr, ex_pc SHALL stay stable until issue or flush.
REQ-029 hazard_stall SHALL = hazard & !flush.
REQ-030 stall_cnt SHALL increment by 1 each cycle hazard_stall=1; saturate at 32'hFFFF_FFFF.
REQ-031 flush SHALL have priority: id_valid<=0, ld_cnt<=0, no issue, no accept that cycle.
REQ-032 load with rd=x0 SHALL NOT arm ld_cnt; rs==x0 SHALL never cause a hazard.
REQ-033 dependency on a load SHALL clear after exactly LOAD_USE_BUBBLES cycles with ex_ready=1.

Reset
REQ-034 rst_n=0 SHALL asynchronously clear id_valid, id_instr, id_pc, ld_rd, ld_cnt, stall_cnt to 0.
REQ-035 during/after reset: ex_valid=0, hazard_stall=0, id_ready=1, ex_instr=0, ex_pc=0.
REQ-036 reset mid-stall SHALL discard held instruction and pending load; first post-reset accept behaves as from empty.

Verification
REQ-037 Stream: ex_ready=1, if_valid=1, addi x1..x4 back-to-back -> one issue per cycle, ex_pc sequence matches, hazard_stall never 1.
REQ-038 Load-use: lw x5 then add x6,x5,x7, LOAD_USE_BUBBLES=1 -> one cycle ex_valid=0, hazard_stall=1, stall_cnt=1, add issues next cycle; with param 3 -> 3 bubbles, stall_cnt=3.
REQ-039 No false hazard: lw x0 then add x6,x0,x0; lw x5 then lui x5 / jal -> zero bubbles.
REQ-040 Backpressure: ex_ready=0 for 4 cycles with instr held -> ex_valid/ex_instr stable, id_ready=0, ld_cnt unchanged.
REQ-041 Flush during load-use stall and simultaneous if_valid=1 -> next cycle id_valid=0, ld_cnt=0, instruction not accepted, id_ready=0 in flush cycle.
REQ-042 Async reset asserted mid-stall (between clock edges) -> outputs at REQ-035 values immediately; stall_cnt=0.

Source files
------------

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: single-slot decode/issue stage with load-use stall, flush and stall counter
module id_issue_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    output logic        ex_valid,
    output logic [31:0] ex_instr,
    output logic [31:0] ex_pc,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        hazard_stall,
    output logic [31:0] stall_cnt
);
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [1:0]  ld_cnt_q, ld_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [4:0]  opc;
    logic        rs1_used, rs2_used, hazard, issue, accept, ld_arm;

    assign opc      = id_instr_q[6:2];
    assign rs1_used = !(opc == 5'b01101 || opc == 5'b00101 || opc == 5'b11011);
    assign rs2_used = opc == 5'b01100 || opc == 5'b01000 || opc == 5'b11000;
    assign hazard   = id_valid_q && ld_cnt_q != 2'd0 && ld_rd_q != 5'd0 &&
                      ((rs1_used && id_instr_q[19:15] == ld_rd_q) ||
                       (rs2_used && id_instr_q[24:20] == ld_rd_q));
    assign ex_valid     = id_valid_q && !hazard && !flush;
    assign ex_instr     = id_instr_q;
    assign ex_pc        = id_pc_q;
    assign issue        = ex_valid && ex_ready;
    assign id_ready     = !flush && (!id_valid_q || issue);
    assign accept       = if_valid && id_ready;
    assign hazard_stall = hazard && !flush;
    assign stall_cnt    = stall_cnt_q;
    assign ld_arm       = issue && opc == 5'b00000 && id_instr_q[11:7] != 5'd0;

    // Next-state: flush kills the slot and any pending load; an issuing load arms the bubble counter
    always_comb begin
        id_valid_d  = flush ? 1'b0 : accept ? 1'b1 : issue ? 1'b0 : id_valid_q;
        id_instr_d  = accept ? if_instr : id_instr_q;
        id_pc_d     = accept ? if_pc : id_pc_q;
        ld_rd_d     = ld_arm ? id_instr_q[11:7] : ld_rd_q;
        ld_cnt_d    = flush ? 2'd0 :
                      ld_arm ? 2'(LOAD_USE_BUBBLES) :
                      (ex_ready && ld_cnt_q != 2'd0) ? ld_cnt_q - 2'd1 : ld_cnt_q;
        stall_cnt_d = (hazard_stall && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q  <= 1'b0;
            id_instr_q  <= 32'd0;
            id_pc_q     <= 32'd0;
            ld_rd_q     <= 5'd0;
            ld_cnt_q    <= 2'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            ld_rd_q     <= ld_rd_d;
            ld_cnt_q    <= ld_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: directed checks of id_issue_ctrl with 1 and 3 load-use bubbles
module tb_id_issue_ctrl;
    logic        clk, rst_n, if_valid, ex_ready, flush;
    logic [31:0] if_instr, if_pc;
    logic        rdy1, exv1, hz1, rdy3, exv3, hz3;
    logic [31:0] exi1, expc1, sc1, exi3, expc3, sc3;
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] LW5   = {12'd0, 5'd0, 3'b010, 5'd5, 7'h03};
    localparam logic [31:0] LW0   = {12'd0, 5'd5, 3'b010, 5'd0, 7'h03};
    localparam logic [31:0] ADD6  = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] ADD00 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] LUI5  = {20'h00028, 5'd5, 7'h37};
    localparam logic [31:0] JAL1  = {20'h00028, 5'd1, 7'h6f};

    id_issue_ctrl #(.LOAD_USE_BUBBLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(rdy1), .ex_valid(exv1), .ex_instr(exi1), .ex_pc(expc1), .ex_ready(ex_ready),
        .flush(flush), .hazard_stall(hz1), .stall_cnt(sc1));

    id_issue_ctrl #(.LOAD_USE_BUBBLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(rdy3), .ex_valid(exv3), .ex_instr(exi3), .ex_pc(expc3), .ex_ready(ex_ready),
        .flush(flush), .hazard_stall(hz3), .stall_cnt(sc3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] addi(input int r);
        return {12'(r), 5'd0, 3'd0, 5'(r), 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic chk_reset_outs;
        chk("rst_exv1", 32'(exv1), 0);
        chk("rst_hz1", 32'(hz1), 0);
        chk("rst_rdy1", 32'(rdy1), 1);
        chk("rst_exi1", exi1, 0);
        chk("rst_expc1", expc1, 0);
        chk("rst_sc1", sc1, 0);
        chk("rst_exv3", 32'(exv3), 0);
        chk("rst_sc3", sc3, 0);
    endtask

    initial begin
        logic [31:0] prog [5];
        prog = '{LW0, ADD00, LW5, LUI5, JAL1};
        rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; ex_ready = 1'b1; flush = 1'b0;
        #3;
        chk_reset_outs();
        nxt();
        rst_n = 1'b1;
        // back-to-back addi stream
        for (int i = 0; i < 5; i++) begin
            if_valid = (i < 4);
            if_instr = addi(i + 1);
            if_pc = 32'h100 + 32'(4 * i);
            smp();
            if (i > 0) begin
                chk("stream_exv", 32'(exv1), 1);
                chk("stream_pc", expc1, 32'h100 + 32'(4 * (i - 1)));
                chk("stream_instr", exi1, addi(i));
            end
            chk("stream_hz", 32'(hz1), 0);
            chk("stream_rdy", 32'(rdy1), 1);
            nxt();
        end
        if_valid = 1'b0;
        smp();
        chk("stream_empty", 32'(exv1), 0);
        nxt();
        // load-use: lw x5 then add x6,x5,x7
        if_valid = 1'b1; if_instr = LW5; if_pc = 32'h200;
        smp();
        chk("lu_rdy", 32'(rdy1), 1);
        nxt();
        if_instr = ADD6; if_pc = 32'h204;
        smp();
        chk("lu_lw_exv1", 32'(exv1), 1);
        chk("lu_lw_pc1", expc1, 32'h200);
        chk("lu_lw_exv3", 32'(exv3), 1);
        nxt();
        if_valid = 1'b0;
        smp();
        chk("lu_c1_hz1", 32'(hz1), 1);
        chk("lu_c1_exv1", 32'(exv1), 0);
        chk("lu_c1_rdy1", 32'(rdy1), 0);
        chk("lu_c1_sc1", sc1, 0);
        chk("lu_c1_hz3", 32'(hz3), 1);
        nxt();
        smp();
        chk("lu_c2_sc1", sc1, 1);
        chk("lu_c2_hz1", 32'(hz1), 0);
        chk("lu_c2_exv1", 32'(exv1), 1);
        chk("lu_c2_pc1", expc1, 32'h204);
        chk("lu_c2_hz3", 32'(hz3), 1);
        chk("lu_c2_sc3", sc3, 1);
        nxt();
        smp();
        chk("lu_c3_exv1", 32'(exv1), 0);
        chk("lu_c3_hz3", 32'(hz3), 1);
        chk("lu_c3_sc3", sc3, 2);
        nxt();
        smp();
        chk("lu_c4_hz3", 32'(hz3), 0);
        chk("lu_c4_exv3", 32'(exv3), 1);
        chk("lu_c4_pc3", expc3, 32'h204);
        chk("lu_c4_sc3", sc3, 3);
        nxt();
        smp();
        chk("lu_c5_exv3", 32'(exv3), 0);
        chk("lu_c5_sc1", sc1, 1);
        nxt();
        // no false hazards: x0 dependencies, lui/jal ignore rs1 field
        for (int i = 0; i < 6; i++) begin
            if_valid = (i < 5);
            if_instr = prog[i % 5];
            if_pc = 32'h300 + 32'(4 * i);
            smp();
            if (i > 0) begin
                chk("nf_exv1", 32'(exv1), 1);
                chk("nf_pc1", expc1, 32'h300 + 32'(4 * (i - 1)));
                chk("nf_exv3", 32'(exv3), 1);
                chk("nf_pc3", expc3, 32'h300 + 32'(4 * (i - 1)));
            end
            chk("nf_hz1", 32'(hz1), 0);
            chk("nf_hz3", 32'(hz3), 0);
            nxt();
        end
        if_valid = 1'b0;
        smp();
        chk("nf_sc1", sc1, 1);
        chk("nf_sc3", sc3, 3);
        nxt();
        nxt();
        // backpressure with a load pending
        if_valid = 1'b1; if_instr = LW5; if_pc = 32'h400;
        nxt();
        if_instr = addi(9); if_pc = 32'h404;
        nxt();
        ex_ready = 1'b0; if_instr = ADD6; if_pc = 32'h408;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("bp_exv1", 32'(exv1), 1);
            chk("bp_exi1", exi1, addi(9));
            chk("bp_pc1", expc1, 32'h404);
            chk("bp_rdy1", 32'(rdy1), 0);
            chk("bp_cnt1", 32'(u1.ld_cnt_q), 1);
            chk("bp_cnt3", 32'(u3.ld_cnt_q), 3);
            nxt();
        end
        ex_ready = 1'b1;
        smp();
        chk("bp_rel_rdy1", 32'(rdy1), 1);
        chk("bp_rel_pc1", expc1, 32'h404);
        nxt();
        // flush while u3 is stalled, with IF offering an instruction
        if_valid = 1'b0;
        smp();
        chk("fl_pre_exv1", 32'(exv1), 1);
        chk("fl_pre_pc1", expc1, 32'h408);
        chk("fl_pre_hz3", 32'(hz3), 1);
        #1;
        flush = 1'b1; if_valid = 1'b1; if_instr = addi(7); if_pc = 32'h40c;
        #1;
        chk("fl_exv1", 32'(exv1), 0);
        chk("fl_rdy1", 32'(rdy1), 0);
        chk("fl_rdy3", 32'(rdy3), 0);
        chk("fl_hz3", 32'(hz3), 0);
        nxt();
        flush = 1'b0; if_valid = 1'b0;
        smp();
        chk("fl_idv1", 32'(u1.id_valid_q), 0);
        chk("fl_idv3", 32'(u3.id_valid_q), 0);
        chk("fl_cnt3", 32'(u3.ld_cnt_q), 0);
        chk("fl_exv3", 32'(exv3), 0);
        chk("fl_rdy3_after", 32'(rdy3), 1);
        chk("fl_sc3", sc3, 3);
        nxt();
        // async reset in the middle of a stall
        if_valid = 1'b1; if_instr = LW5; if_pc = 32'h500;
        nxt();
        if_instr = ADD6; if_pc = 32'h504;
        nxt();
        if_valid = 1'b0;
        smp();
        chk("ar_pre_hz1", 32'(hz1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        nxt();
        rst_n = 1'b1;
        if_valid = 1'b1; if_instr = addi(1); if_pc = 32'h600;
        smp();
        chk("ar_post_rdy1", 32'(rdy1), 1);
        chk("ar_post_exv1", 32'(exv1), 0);
        nxt();
        if_valid = 1'b0;
        smp();
        chk("ar_post_issue1", 32'(exv1), 1);
        chk("ar_post_pc1", expc1, 32'h600);
        chk("ar_post_hz1", 32'(hz1), 0);
        chk("ar_post_exv3", 32'(exv3), 1);
        chk("ar_post_cnt1", 32'(u1.ld_cnt_q), 0);
        nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
